ysyx_220066_dmem_bridge: RTL
============================

Name: ysyx_220066_dmem_bridge

Overview:
- Data-memory bridge directly downstream of the CPU core's M stage.
- Consumes the core's load/store request (MemRd, MemWr, MemOp, addr, data_Wr). Issues one aligned 64-bit transaction on a valid/ready memory bus.
- Returns the sign- or zero-extended load data and completion status to the core's WB inputs (data_Rd, data_Rd_valid, data_Rd_error).
- One transaction in flight; the core is stalled via busy.

Parameters:
- TIMEOUT, 255: max cycles waiting in RESP before a bus error is reported; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- MemRd  in  1  load request from M stage
- MemWr  in  1  store request from M stage
- MemOp  in  3  RV funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- addr  in  64  byte address
- data_Wr  in  64  store data, right-aligned
- busy  out  1  high while a request is captured and not yet completed
- data_Rd  out  64  extended load data; 0 for stores and errors
- data_Rd_valid  out  1  one-cycle completion pulse
- data_Rd_error  out  1  qualifies data_Rd_valid
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_addr  out  64  addr with bits [2:0] cleared
- bus_wen  out  1  1 = write
- bus_wdata  out  64  data_Wr shifted to lane addr[2:0]
- bus_wstrb  out  8  byte enables
- bus_resp_valid  in  1  response valid
- bus_rdata  in  64  raw 64-bit read data
- bus_resp_err  in  1  bus error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: busy, data_Rd, data_Rd_valid, data_Rd_error, bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb.
  - The timeout counter clears.
  - If reset is asserted mid-transaction, the transaction is abandoned. A bus_resp_valid arriving after release while in IDLE is ignored.
- States: IDLE, REQ, RESP, ERR.
- IDLE:
  - A request is sampled when MemRd|MemWr=1. Request fields are registered. busy is set in the next cycle and stays high until the cycle data_Rd_valid pulses.
  - An illegal request goes to ERR with no bus activity. Illegal means any of:
    - MemRd&MemWr both high;
    - misaligned address: H/HU needs addr[0]=0; W/WU needs addr[1:0]=0; D needs addr[2:0]=0;
    - MemOp=111;
    - MemWr with MemOp[2]=1.
  - Otherwise the request goes to REQ.
- REQ:
  - bus_req_valid=1. bus_addr, bus_wen, bus_wdata and bus_wstrb are held stable until bus_req_ready=1.
  - On bus_req_ready, go to RESP and drop bus_req_valid in the following cycle.
- wstrb rules:
  - B: 8'b1 << addr[2:0]
  - H: 8'b11 << addr[2:0]
  - W: 8'hF << addr[2:0]
  - D: 8'hFF
  - Loads drive strobe 8'hFF.
- wdata: data_Wr << (8*addr[2:0]), truncated to 64 bits.
- RESP:
  - The counter increments every cycle.
  - On bus_resp_valid, go to IDLE with registered outputs in the next cycle:
    - data_Rd_valid=1;
    - data_Rd_error=bus_resp_err;
    - data_Rd = extract(bus_rdata >> 8*addr[2:0]), sign-extended for B/H/W and zero-extended for BU/HU/WU/D.
    - For stores, or when bus_resp_err=1, data_Rd=0.
  - If the counter reaches TIMEOUT (TIMEOUT≠0) without a response, complete with data_Rd_error=1.
  - If a response and the timeout land in the same cycle, the response wins.
- ERR: one cycle, then go to IDLE with data_Rd_valid=1, data_Rd_error=1, data_Rd=0.
- data_Rd_valid and data_Rd_error are single-cycle pulses. data_Rd holds its value until the next completion.
- While busy=1, new MemRd/MemWr values are ignored. The core must hold or withdraw the request; the bridge never double-issues.
- A new request can be sampled in the same cycle data_Rd_valid is high, since state is already IDLE.
- Latency, request sample edge to data_Rd_valid: minimum 3 cycles when the bus is zero-wait; ERR path is 2 cycles.

Decomposition:
- Shared package: MemOp encodings (MOP_B…MOP_WU), FSM state encodings, and the strobe/alignment helper function.
- Sub-module ysyx_220066_load_align (combinational): takes rdata, offset and MemOp, returns the extended 64-bit data. It is reused by any later cache refill path.
- The FSM, counter and request registers stay in the top of the block.

Test Plan:
- Load LW, addr=0x8000_0004, bus_rdata=0x8765_4321_0000_0000, zero-wait bus -> bus_addr=0x8000_0000, data_Rd=0xFFFF_FFFF_8765_4321, data_Rd_valid pulses at cycle 3, error=0.
- Store SH, addr=0x1006, data_Wr=0xABCD -> bus_wstrb=8'hC0, bus_wdata=0xABCD_0000_0000_0000, bus_wen=1. Signals stay stable for 4 cycles while bus_req_ready=0. Completion reports data_Rd=0, error=0.
- Misaligned LD, addr=0x1004 -> no bus_req_valid ever; data_Rd_valid=1 with data_Rd_error=1 two cycles after the request.
- LBU, addr=0x7, bus_rdata=0x80xx_xxxx_xxxx_xxxx -> data_Rd=0x80. The same case as LB -> data_Rd=0xFFFF_FFFF_FFFF_FF80.
- TIMEOUT=4, bus never responds -> data_Rd_error pulse 4 cycles after entering RESP. A late bus_resp_valid in IDLE is ignored.
- Assert rst during RESP -> all outputs 0 immediately and busy=0. A new LD request after release completes normally.

Source files
------------

// File: rtl/ysyx_220066_dmem_bridge_pkg.sv
// Shared encodings and helpers for the M-stage data-memory bridge:
// RV load/store funct3 codes, bridge FSM states, strobe and alignment rules.
package ysyx_220066_dmem_bridge_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_D  = 3'b011;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;
  localparam logic [2:0] MOP_WU = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // Loads always fetch the full doubleword, so they enable every lane.
  function automatic logic [7:0] lane_strobe(input logic [2:0] op, input logic wr,
                                             input logic [2:0] off);
    logic [7:0] s;
    s = 8'hFF;
    if (wr) begin
      case (op[1:0])
        2'b00:   s = 8'h01 << off;
        2'b01:   s = 8'h03 << off;
        2'b10:   s = 8'h0F << off;
        default: s = 8'hFF;
      endcase
    end
    return s;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [2:0] off);
    logic m;
    case (op[1:0])
      2'b01:   m = off[0];
      2'b10:   m = |off[1:0];
      2'b11:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic illegal_req(input logic rd, input logic wr,
                                       input logic [2:0] op, input logic [2:0] off);
    return (rd & wr) | (op == 3'b111) | (wr & op[2]) | misaligned(op, off);
  endfunction

endpackage

// File: rtl/ysyx_220066_dmem_bridge_load_align.sv
// Extracts and extends a load result from a raw 64-bit doubleword.
// Purely combinational so a cache refill path can share it.
module ysyx_220066_load_align
  import ysyx_220066_dmem_bridge_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  mem_op,
  output logic [63:0] data
);

  logic [63:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = 64'd0;
    case (mem_op)
      MOP_B:   data = {{56{lane[7]}}, lane[7:0]};
      MOP_H:   data = {{48{lane[15]}}, lane[15:0]};
      MOP_W:   data = {{32{lane[31]}}, lane[31:0]};
      MOP_D:   data = lane;
      MOP_BU:  data = {56'd0, lane[7:0]};
      MOP_HU:  data = {48'd0, lane[15:0]};
      MOP_WU:  data = {32'd0, lane[31:0]};
      default: data = 64'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_dmem_bridge.sv
// M-stage load/store bridge: one aligned 64-bit valid/ready bus transaction
// per request, with the core stalled on busy until the completion pulse.
//
// state | meaning
// IDLE  | waiting for MemRd/MemWr; completion pulses are visible here
// REQ   | bus_req_valid high, request fields frozen until bus_req_ready
// RESP  | waiting for bus_resp_valid, timeout counter running
// ERR   | illegal request, reports an error next cycle without bus activity
module ysyx_220066_dmem_bridge
  import ysyx_220066_dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [2:0]  MemOp,
  input  logic [63:0] addr,
  input  logic [63:0] data_Wr,
  output logic        busy,
  output logic [63:0] data_Rd,
  output logic        data_Rd_valid,
  output logic        data_Rd_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_rdata,
  input  logic        bus_resp_err
);

  localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [2:0]       off_q;
  logic             wr_q;
  logic [63:0]      load_data;

  ysyx_220066_load_align u_load_align (
    .rdata  (bus_rdata),
    .offset (off_q),
    .mem_op (op_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_q          <= 3'd0;
      off_q         <= 3'd0;
      wr_q          <= 1'b0;
      busy          <= 1'b0;
      data_Rd       <= 64'd0;
      data_Rd_valid <= 1'b0;
      data_Rd_error <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_addr      <= 64'd0;
      bus_wen       <= 1'b0;
      bus_wdata     <= 64'd0;
      bus_wstrb     <= 8'd0;
    end else begin
      data_Rd_valid <= 1'b0;
      data_Rd_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MemRd | MemWr) begin
            busy  <= 1'b1;
            op_q  <= MemOp;
            off_q <= addr[2:0];
            wr_q  <= MemWr;
            if (illegal_req(MemRd, MemWr, MemOp, addr[2:0])) begin
              state <= S_ERR;
            end else begin
              state         <= S_REQ;
              bus_req_valid <= 1'b1;
              bus_addr      <= {addr[63:3], 3'b000};
              bus_wen       <= MemWr;
              bus_wdata     <= data_Wr << {addr[2:0], 3'b000};
              bus_wstrb     <= lane_strobe(MemOp, MemWr, addr[2:0]);
            end
          end
        end
        S_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          // A response in the timeout cycle still wins.
          if (bus_resp_valid) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            data_Rd_valid <= 1'b1;
            data_Rd_error <= bus_resp_err;
            data_Rd       <= (wr_q | bus_resp_err) ? 64'd0 : load_data;
          end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            data_Rd_valid <= 1'b1;
            data_Rd_error <= 1'b1;
            data_Rd       <= 64'd0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ERR: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          data_Rd_valid <= 1'b1;
          data_Rd_error <= 1'b1;
          data_Rd       <= 64'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
